telemetry_framer: RTL
=====================

Name: telemetry_framer

Overview:
- Packet source that sits directly upstream of the buffered UART transmitter and drives its 32-bit write/status port.
- On a START pulse it reads NWORDS 32-bit words from a register-file snapshot port and emits one framed byte stream: sync, length, payload, checksum.
- The transmitter exposes only an "empty" status bit and no full flag, so the framer paces its writes in bounded bursts. It issues a burst only after observing empty, which prevents FIFO overrun.

Parameters:
- BURST, 16: maximum bytes written per burst after empty is seen. Must be ≤ 2**TX_DEPTH − 1.
- ADDR_W, 4: width of SRC_ADDR and NWORDS.
- GUARD, 2: idle cycles after a burst before TX_RD[0] is sampled again, to cover status latency.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- START  in  1  one-cycle frame request; ignored while BUSY
- NWORDS  in  ADDR_W  payload word count, 0..2**ADDR_W−1; latched on accepted START
- SRC_ADDR  out  ADDR_W  word index into the snapshot source
- SRC_DATA  in  32  source word, valid exactly 1 cycle after SRC_ADDR
- TX_WD  out  32  write data to the transmitter; byte in [7:0], [31:8] = 0
- TX_WE  out  1  one-cycle write strobe to the transmitter
- TX_RD  in  32  transmitter status; bit0 = FIFO empty and UART idle
- BUSY  out  1  high from accepted START through the final checksum write
- DONE  out  1  one-cycle pulse in the cycle after the checksum write

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-frame aborts immediately; no further TX_WE and no DONE.
- Frame byte order:
  - 0xA5, 0x5A
  - LEN = 4*NWORDS (8 bits)
  - payload: words 0..NWORDS−1, each little-endian (byte [7:0] first)
  - CHK = (LEN + sum of payload bytes) mod 256
- NWORDS = 0 gives the 4-byte frame A5 5A 00 00.
- States:
  - IDLE: START → latch NWORDS; clear CHK, word index and byte counter; BUSY=1; → WAIT_EMPTY.
  - WAIT_EMPTY: TX_RD[0]=1 → clear burst count, → EMIT. Otherwise hold.
  - EMIT: one header byte or CHK byte per cycle with TX_WE=1. At the payload start, → FETCH.
  - FETCH: drive SRC_ADDR = word index, TX_WE=0; → LOAD.
  - LOAD: capture SRC_DATA into a 32-bit shift register; → SEND.
  - SEND: 4 cycles, one byte per cycle with TX_WE=1, shift right by 8, accumulate CHK. After byte 3: word index++, then → FETCH, or → EMIT(CHK) when the index equals NWORDS.
  - PAUSE: GUARD cycles with TX_WE=0; → WAIT_EMPTY.
  - FIN: DONE=1 for 1 cycle, BUSY=0; → IDLE.
- Burst rule:
  - The burst counter increments on every TX_WE.
  - When it reaches BURST and the frame is not finished, enter PAUSE before the next byte.
  - FETCH/LOAD/SEND resume from the saved word and byte position after the pause. The shift register is kept; a word is never refetched mid-word.
  - The next burst starts only when empty is re-observed.
- Latency with TX_RD[0] held 1 and frame ≤ BURST bytes:
  - The first TX_WE occurs 2 cycles after START (IDLE→WAIT_EMPTY→EMIT).
  - Each word costs 6 cycles (FETCH, LOAD, 4×SEND).
- CHK uses 8-bit wrap-around arithmetic.
- SRC_ADDR holds its last value outside FETCH. START during BUSY is dropped, not queued.
- TX_WE is never asserted in IDLE, WAIT_EMPTY, FETCH, LOAD, PAUSE or FIN.

Test Plan:
- NWORDS=1, SRC word0=0x44332211, TX_RD=1 constant → TX_WE bytes A5,5A,04,11,22,33,44,AE; first write 2 cycles after START; then DONE 1 cycle, BUSY low.
- NWORDS=0 → bytes A5,5A,00,00; SRC_ADDR never sampled; DONE once.
- NWORDS=1, word0=0xFFFFFFFF → CHK = (04+4×FF) mod 256 = 0x00.
- NWORDS=15, BURST=16, with the real transmitter (115200 baud) attached:
  - 64 bytes are written in 4 bursts of 16.
  - No TX_WE occurs while empty=0.
  - The UART line decodes the exact frame with no loss or duplication.
- START pulsed again mid-frame → ignored; exactly one frame and one DONE.
- RESET asserted during the SEND of word 2 → next cycle all outputs 0, state IDLE; a new START produces a complete, correct frame.

Source files
------------

// File: rtl/telemetry_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_framer_if
// Brief    : Write/status port between the framer and the buffered UART TX.
// Revision : 1.0  initial release
// ============================================================================
interface telemetry_framer_if;
   logic [31:0] TX_WD;
   logic        TX_WE;
   logic [31:0] TX_RD;

   modport master (output TX_WD, output TX_WE, input  TX_RD);
   modport slave  (input  TX_WD, input  TX_WE, output TX_RD);
endinterface
`default_nettype wire

// File: rtl/telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_framer
// Brief    : Frames a snapshot (A5 5A LEN payload CHK) and paces UART writes
//            in bursts issued only after the transmitter reports empty.
// Revision : 1.0  initial release
// ============================================================================
module telemetry_framer #(
   parameter int BURST  = 16,
   parameter int ADDR_W = 4,
   parameter int GUARD  = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [ADDR_W-1:0]     NWORDS,
   output logic [ADDR_W-1:0]     SRC_ADDR,
   input  logic [31:0]           SRC_DATA,
   telemetry_framer_if.master    tx,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int BW = $clog2(BURST + 1);
   localparam int PW = (GUARD > 1) ? $clog2(GUARD) : 1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_EMPTY = 3'd1,
      ST_EMIT       = 3'd2,
      ST_FETCH      = 3'd3,
      ST_LOAD       = 3'd4,
      ST_SEND       = 3'd5,
      ST_PAUSE      = 3'd6,
      ST_FIN        = 3'd7
   } state_t;

   state_t            state_q, state_d, resume_q, resume_d, nxt;
   logic [ADDR_W-1:0] nwords_q, nwords_d, word_idx_q, word_idx_d;
   logic [ADDR_W-1:0] src_addr_q, src_addr_d;
   logic [1:0]        hdr_q, hdr_d, sbyte_q, sbyte_d;
   logic [31:0]       shift_q, shift_d;
   logic [7:0]        chk_q, chk_d, len, tx_byte;
   logic [BW-1:0]     burst_q, burst_d;
   logic [PW-1:0]     pause_q, pause_d;
   logic              tx_we;
   logic              unused_rd;

   assign len       = 8'({nwords_q, 2'b00});
   assign unused_rd = &{1'b0, tx.TX_RD[31:1]};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         resume_q   <= ST_EMIT;
         nwords_q   <= '0;
         word_idx_q <= '0;
         src_addr_q <= '0;
         hdr_q      <= '0;
         sbyte_q    <= '0;
         shift_q    <= '0;
         chk_q      <= '0;
         burst_q    <= '0;
         pause_q    <= '0;
      end else begin
         state_q    <= state_d;
         resume_q   <= resume_d;
         nwords_q   <= nwords_d;
         word_idx_q <= word_idx_d;
         src_addr_q <= src_addr_d;
         hdr_q      <= hdr_d;
         sbyte_q    <= sbyte_d;
         shift_q    <= shift_d;
         chk_q      <= chk_d;
         burst_q    <= burst_d;
         pause_q    <= pause_d;
      end
   end

   always_comb begin
      nxt        = state_q;
      resume_d   = resume_q;
      nwords_d   = nwords_q;
      word_idx_d = word_idx_q;
      src_addr_d = src_addr_q;
      hdr_d      = hdr_q;
      sbyte_d    = sbyte_q;
      shift_d    = shift_q;
      chk_d      = chk_q;
      burst_d    = burst_q;
      pause_d    = pause_q;
      tx_we      = 1'b0;
      tx_byte    = 8'h00;
      SRC_ADDR   = src_addr_q;
      BUSY       = (state_q != ST_IDLE) && (state_q != ST_FIN);
      DONE       = (state_q == ST_FIN);

      case (state_q)
         ST_IDLE, ST_FIN: begin
            nxt = ST_IDLE;
            if (START) begin
               nwords_d   = NWORDS;
               chk_d      = 8'h00;
               word_idx_d = '0;
               hdr_d      = 2'd0;
               sbyte_d    = 2'd0;
               resume_d   = ST_EMIT;
               nxt        = ST_WAIT_EMPTY;
            end
         end
         ST_WAIT_EMPTY: begin
            if (tx.TX_RD[0]) begin
               burst_d = '0;
               nxt     = resume_q;
            end
         end
         ST_EMIT: begin
            tx_we = 1'b1;
            case (hdr_q)
               2'd0: begin tx_byte = 8'hA5; hdr_d = 2'd1; end
               2'd1: begin tx_byte = 8'h5A; hdr_d = 2'd2; end
               2'd2: begin
                  tx_byte = len;
                  chk_d   = chk_q + len;
                  hdr_d   = 2'd3;
                  nxt     = (nwords_q == '0) ? ST_EMIT : ST_FETCH;
               end
               default: begin tx_byte = chk_q; nxt = ST_FIN; end
            endcase
         end
         ST_FETCH: begin
            SRC_ADDR   = word_idx_q;
            src_addr_d = word_idx_q;
            nxt        = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d = SRC_DATA;
            sbyte_d = 2'd0;
            nxt     = ST_SEND;
         end
         ST_SEND: begin
            tx_we   = 1'b1;
            tx_byte = shift_q[7:0];
            shift_d = shift_q >> 8;
            chk_d   = chk_q + shift_q[7:0];
            sbyte_d = sbyte_q + 2'd1;
            if (sbyte_q == 2'd3) begin
               word_idx_d = word_idx_q + ADDR_W'(1);
               nxt = (word_idx_q + ADDR_W'(1) == nwords_q) ? ST_EMIT : ST_FETCH;
            end
         end
         ST_PAUSE: begin
            pause_d = pause_q + PW'(1);
            if (pause_q == PW'(GUARD - 1)) nxt = ST_WAIT_EMPTY;
         end
         default: nxt = ST_IDLE;
      endcase

      // A full burst diverts to PAUSE and remembers where the stream left off.
      if (tx_we) begin
         burst_d = burst_q + BW'(1);
         if ((burst_q + BW'(1) == BW'(BURST)) && (nxt != ST_FIN)) begin
            resume_d = nxt;
            pause_d  = '0;
            nxt      = ST_PAUSE;
         end
      end

      state_d = nxt;
   end

   assign tx.TX_WE = tx_we;
   assign tx.TX_WD = {24'd0, tx_byte};

endmodule
`default_nettype wire
